// File: rtl/mem_wb_sequencer_if.sv
// Bus bundle between the EX stage / data memory / register file and the MEM-WB sequencer.
// The sequencer takes the slave view; whoever drives instructions and serves memory takes master.
interface mem_wb_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [5:0]        in_opcode;
  logic [3:0]        in_rd;
  logic              in_reg_write;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_sdata_lo;
  logic [DATA_W-1:0] in_sdata_hi;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              reg_write;
  logic [3:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              stall;
  logic              exception;

  modport master (
    output in_valid, in_opcode, in_rd, in_reg_write, in_result, in_sdata_lo, in_sdata_hi,
    output mem_rdata,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  reg_write, wb_rd, wb_data, stall, exception
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_reg_write, in_result, in_sdata_lo, in_sdata_hi,
    input  mem_rdata,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output reg_write, wb_rd, wb_data, stall, exception
  );
endinterface

// File: rtl/mem_wb_sequencer.sv
// Memory/write-back sequencer: single-word LW/SW, double-word LDW/SDW over two cycles,
// ALU pass-through, R15 write protection and alignment/odd-pair exceptions.
module mem_wb_sequencer #(
  parameter int         DATA_W = 32,
  parameter logic [5:0] OP_LW  = 6'd6,
  parameter logic [5:0] OP_SW  = 6'd7,
  parameter logic [5:0] OP_LDW = 6'd8,
  parameter logic [5:0] OP_SDW = 6'd9
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_wb_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        op_q;
  logic [3:0]        rd_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] hi_q;
  logic              rw_q;

  logic              accept;
  logic              exc_c;
  logic              stall_c;
  logic [DATA_W-1:0] addr_c;
  logic              rd_en_c;
  logic              wr_en_c;
  logic [DATA_W-1:0] wdata_c;
  logic              rw_c;
  logic [3:0]        wb_rd_c;
  logic [DATA_W-1:0] wb_data_c;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LDW);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SDW);
  endfunction

  function automatic logic is_double(input logic [5:0] op);
    return (op == OP_LDW) || (op == OP_SDW);
  endfunction

  // Misaligned address on any memory op, or an odd first register of a pair.
  function automatic logic mem_fault(input logic [5:0] op, input logic [3:0] rd,
                                     input logic [DATA_W-1:0] addr);
    return (is_load(op) || is_store(op)) &&
           ((addr[1:0] != 2'b00) || (is_double(op) && rd[0]));
  endfunction

  assign exc_c   = (state_q == ACC0) && mem_fault(op_q, rd_q, res_q);
  assign stall_c = (state_q == ACC0) && is_double(op_q) && !exc_c;
  assign accept  = bus.in_valid && !stall_c;

  // Stage boundary: instruction fields captured from EX on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= bus.in_opcode;
        rd_q  <= bus.in_rd;
        res_q <= bus.in_result;
        lo_q  <= bus.in_sdata_lo;
        hi_q  <= bus.in_sdata_hi;
        rw_q  <= bus.in_reg_write;
      end
    end
  end

  always_comb begin
    state_d   = IDLE;
    addr_c    = '0;
    rd_en_c   = 1'b0;
    wr_en_c   = 1'b0;
    wdata_c   = '0;
    rw_c      = 1'b0;
    wb_rd_c   = '0;
    wb_data_c = '0;

    unique case (state_q)
      IDLE: begin
        state_d = accept ? ACC0 : IDLE;
      end
      ACC0: begin
        if (stall_c) state_d = ACC1;
        else         state_d = accept ? ACC0 : IDLE;

        if (exc_c) begin
          rw_c = 1'b0;
        end else if (is_load(op_q)) begin
          addr_c    = res_q;
          rd_en_c   = 1'b1;
          rw_c      = 1'b1;
          wb_rd_c   = rd_q;
          wb_data_c = bus.mem_rdata;
        end else if (is_store(op_q)) begin
          addr_c  = res_q;
          wr_en_c = 1'b1;
          wdata_c = lo_q;
        end else begin
          rw_c      = rw_q;
          wb_rd_c   = rd_q;
          wb_data_c = res_q;
        end
      end
      ACC1: begin
        state_d = accept ? ACC0 : IDLE;
        addr_c  = res_q + DATA_W'(4);
        if (op_q == OP_LDW) begin
          rd_en_c   = 1'b1;
          rw_c      = 1'b1;
          wb_rd_c   = rd_q + 4'd1;
          wb_data_c = bus.mem_rdata;
        end else begin
          wr_en_c = 1'b1;
          wdata_c = hi_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // R15 holds the PC and is never written from this stage.
    if (wb_rd_c == 4'hF) rw_c = 1'b0;
  end

  assign bus.mem_addr  = addr_c;
  assign bus.mem_rd_en = rd_en_c;
  assign bus.mem_wr_en = wr_en_c;
  assign bus.mem_wdata = wdata_c;
  assign bus.reg_write = rw_c;
  assign bus.wb_rd     = wb_rd_c;
  assign bus.wb_data   = wb_data_c;
  assign bus.stall     = stall_c;
  assign bus.exception = exc_c;

endmodule

// File: tb/tb_mem_wb_sequencer.sv
// Bench for mem_wb_sequencer: directed scenarios then random traffic, checked cycle by cycle
// against a transaction-level model that expands each accepted instruction into its output cycles.
module tb_mem_wb_sequencer;

  localparam logic [5:0] OP_LW  = 6'd6;
  localparam logic [5:0] OP_SW  = 6'd7;
  localparam logic [5:0] OP_LDW = 6'd8;
  localparam logic [5:0] OP_SDW = 6'd9;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wdata;
    logic        rw;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        exc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;
  exp_t q[$];

  mem_wb_sequencer_if bus ();

  mem_wb_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory contents as a fixed function of the address.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hA;
    if (a == 32'h104) return 32'hB;
    return (a * 32'h9E3779B1) + 32'h1357;
  endfunction

  assign bus.mem_rdata = mem_val(bus.mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string ctx, input exp_t e);
    chk({ctx, ".mem_addr"},  bus.mem_addr,          e.addr);
    chk({ctx, ".mem_rd_en"}, 32'(bus.mem_rd_en),    32'(e.rd_en));
    chk({ctx, ".mem_wr_en"}, 32'(bus.mem_wr_en),    32'(e.wr_en));
    chk({ctx, ".mem_wdata"}, bus.mem_wdata,         e.wdata);
    chk({ctx, ".reg_write"}, 32'(bus.reg_write),    32'(e.rw));
    chk({ctx, ".wb_rd"},     32'(bus.wb_rd),        32'(e.wb_rd));
    chk({ctx, ".wb_data"},   bus.wb_data,           e.wb_data);
    chk({ctx, ".stall"},     32'(bus.stall),        32'(e.stall));
    chk({ctx, ".exception"}, 32'(bus.exception),    32'(e.exc));
  endtask

  // Expand one accepted instruction into the output cycles it must produce.
  task automatic expand(input logic [5:0] op, input logic [3:0] rd, input logic rw,
                        input logic [31:0] res, input logic [31:0] lo, input logic [31:0] hi);
    exp_t a, b;
    logic is_mem, is_dw;
    logic [3:0] rd2;
    a = '0;
    b = '0;
    is_mem = (op >= OP_LW) && (op <= OP_SDW);
    is_dw  = (op == OP_LDW) || (op == OP_SDW);
    rd2    = rd + 4'd1;
    if (is_mem && ((res[1:0] != 2'b00) || (is_dw && rd[0]))) begin
      a.exc = 1'b1;
      q.push_back(a);
    end else if (op == OP_LW || op == OP_LDW) begin
      a.addr = res; a.rd_en = 1'b1; a.wb_rd = rd; a.wb_data = mem_val(res); a.rw = (rd != 4'd15);
      a.stall = is_dw;
      q.push_back(a);
      if (is_dw) begin
        b.addr = res + 32'd4; b.rd_en = 1'b1; b.wb_rd = rd2; b.wb_data = mem_val(res + 32'd4);
        b.rw = (rd2 != 4'd15);
        q.push_back(b);
      end
    end else if (op == OP_SW || op == OP_SDW) begin
      a.addr = res; a.wr_en = 1'b1; a.wdata = lo; a.stall = is_dw;
      q.push_back(a);
      if (is_dw) begin
        b.addr = res + 32'd4; b.wr_en = 1'b1; b.wdata = hi;
        q.push_back(b);
      end
    end else begin
      a.rw = rw && (rd != 4'd15); a.wb_rd = rd; a.wb_data = res;
      q.push_back(a);
    end
  endtask

  // One clock cycle: check this cycle's outputs, present the next instruction.
  task automatic step(input string ctx, input logic v, input logic [5:0] op, input logic [3:0] rd,
                      input logic rw, input logic [31:0] res, input logic [31:0] lo,
                      input logic [31:0] hi);
    exp_t cur;
    cur = '0;
    if (q.size() > 0) cur = q.pop_front();
    check_out(ctx, cur);
    bus.in_valid     = v;
    bus.in_opcode    = op;
    bus.in_rd        = rd;
    bus.in_reg_write = rw;
    bus.in_result    = res;
    bus.in_sdata_lo  = lo;
    bus.in_sdata_hi  = hi;
    if (v && !cur.stall) expand(op, rd, rw, res, lo, hi);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1'b0, 6'd0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    exp_t cur;
    logic [31:0] r;
    logic [5:0]  op;
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_reg_write = 1'b0;
    bus.in_result = '0; bus.in_sdata_lo = '0; bus.in_sdata_hi = '0;
    repeat (3) @(negedge clk);
    check_out("reset", '0);
    reset_n = 1'b1;

    // ALU pass-through.
    step("t1_issue", 1'b1, 6'd0, 4'd3, 1'b1, 32'h1234, 32'd0, 32'd0);
    idle("t1_wb");

    // LDW with an instruction ignored during ACC0 and an LW accepted during ACC1.
    step("t2_issue", 1'b1, OP_LDW, 4'd4, 1'b0, 32'h100, 32'd0, 32'd0);
    step("t2_acc0",  1'b1, OP_LW,  4'd2, 1'b0, 32'h200, 32'd0, 32'd0);
    step("t2_acc1",  1'b1, OP_LW,  4'd7, 1'b0, 32'h300, 32'd0, 32'd0);
    idle("t2_lw");

    // SDW whose second word wraps to address 0.
    step("t3_issue", 1'b1, OP_SDW, 4'd6, 1'b0, 32'hFFFF_FFFC, 32'h11, 32'h22);
    idle("t3_acc0");
    idle("t3_acc1");

    // Odd register pair and misaligned address.
    step("t4_ldw",  1'b1, OP_LDW, 4'd5, 1'b0, 32'h100, 32'd0, 32'd0);
    step("t4_lw",   1'b1, OP_LW,  4'd1, 1'b0, 32'h102, 32'd0, 32'd0);
    idle("t4_lwx");

    // LDW into R14/R15: second write suppressed, read still performed.
    step("t5_issue", 1'b1, OP_LDW, 4'd14, 1'b0, 32'h300, 32'd0, 32'd0);
    idle("t5_acc0");
    idle("t5_acc1");
    step("t5_alu15", 1'b1, 6'd12, 4'd15, 1'b1, 32'h55, 32'd0, 32'd0);
    idle("t5_alu15wb");

    // Asynchronous reset in the middle of an SDW.
    step("t6_issue", 1'b1, OP_SDW, 4'd6, 1'b0, 32'h40, 32'h55, 32'h66);
    cur = q.pop_front();
    check_out("t6_acc0", cur);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_out("t6_rst", '0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle("t6_after0");
    idle("t6_after1");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        op = 6'($urandom_range(10, 63));
        if ($urandom_range(0, 1) == 0) op = 6'($urandom_range(0, 5));
      end else begin
        op = 6'($urandom_range(6, 9));
      end
      r = $urandom;
      if ($urandom_range(0, 7) != 0) r[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) r = 32'hFFFF_FFFC;
      step("rnd", ($urandom_range(0, 3) != 0), op, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), r, $urandom, $urandom);
    end
    repeat (3) idle("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
